// File: rtl/layer_sequencer.sv
// Streams input samples into a neuron layer, collects every neuron output, then emits them in order.
// Optional WAIT-state timeout with an ERR state is enabled by defining LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer #(
    parameter int NN         = 30,
    parameter int NUM_INPUTS = 784,
    parameter int dataWidth  = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [dataWidth-1:0]    s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [dataWidth-1:0]    l_x_in,
    output logic                    l_x_valid,
    input  logic [NN-1:0]           l_o_valid,
    input  logic [NN*dataWidth-1:0] l_x_out,
    output logic [dataWidth-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

`ifdef LAYER_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, FEED, WAIT, DRAIN, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;
`endif

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     in_cnt;
    logic [NN-1:0]        mask, mask_nxt;
    logic [IDX_W-1:0]     idx;
    logic [dataWidth-1:0] res_buf [NN];
    logic                 s_fire, m_fire, last_in, last_out, restart;

    assign s_fire   = (state == FEED) && s_valid;
    assign m_fire   = (state == DRAIN) && m_ready;
    assign last_in  = (in_cnt == CNT_W'(NUM_INPUTS - 1));
    assign last_out = (idx == IDX_W'(NN - 1));
    assign mask_nxt = mask | l_o_valid;

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] wait_cnt;
    logic             tmo_hit;

    assign tmo_hit = (wait_cnt == TMO_W'(TIMEOUT - 1));
    assign restart = start && ((state == IDLE) || (state == ERR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= '0;
        else if (restart)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + TMO_W'(1);
    end
`else
    assign restart = start && (state == IDLE);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FEED;
            FEED:  if (s_fire && last_in) state_nxt = WAIT;
            WAIT: begin
                // Bits arriving in the completing cycle count toward the full mask.
                if (&mask_nxt)
                    state_nxt = DRAIN;
`ifdef LAYER_SEQ_TIMEOUT_EN
                else if (tmo_hit)
                    state_nxt = ERR;
`endif
            end
            DRAIN: if (m_fire && last_out) state_nxt = IDLE;
`ifdef LAYER_SEQ_TIMEOUT_EN
            ERR:   if (start) state_nxt = FEED;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt    <= '0;
            mask      <= '0;
            idx       <= '0;
            l_x_in    <= '0;
            l_x_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            l_x_valid <= s_fire;
            if (s_fire)
                l_x_in <= s_data;
            // done is registered, so it pulses in the first IDLE cycle after the last beat.
            done <= m_fire && last_out;
            if (restart) begin
                in_cnt <= '0;
                mask   <= '0;
                idx    <= '0;
            end else begin
                if (s_fire)
                    in_cnt <= in_cnt + CNT_W'(1);
                if (state == WAIT)
                    mask <= mask_nxt;
                if (m_fire)
                    idx <= idx + IDX_W'(1);
            end
        end
    end

    // Result buffer carries no reset; it is only read in DRAIN, which follows a complete WAIT.
    always_ff @(posedge clk) begin
        if (state == WAIT) begin
            for (int i = 0; i < NN; i++) begin
                if (l_o_valid[i])
                    res_buf[i] <= l_x_out[i*dataWidth +: dataWidth];
            end
        end
    end

    assign s_ready = (state == FEED);
    assign m_valid = (state == DRAIN);
    assign m_data  = m_valid ? res_buf[idx] : '0;
    assign m_last  = m_valid && last_out;
    assign busy    = (state != IDLE);
`ifdef LAYER_SEQ_TIMEOUT_EN
    assign error   = (state == ERR);
`else
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (NN=4, NUM_INPUTS=8): vector table plus multi-cycle corner sequences.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, s_valid, s_ready, l_x_valid, m_valid, m_ready, m_last, busy, done, error;
    logic [15:0] s_data, l_x_in, m_data;
    logic [3:0]  l_o_valid;
    logic [63:0] l_x_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.NN(4), .NUM_INPUTS(8), .dataWidth(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .l_x_in(l_x_in), .l_x_valid(l_x_valid),
        .l_o_valid(l_o_valid), .l_x_out(l_x_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .error(error)
    );

    typedef struct {
        logic        st;
        logic        sv;
        logic [15:0] sd;
        logic [3:0]  ov;
        logic [63:0] xo;
        logic        mr;
        logic [63:0] ex;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] pk(input logic sr, input logic lxv, input logic [15:0] lxi,
                                       input logic mv, input logic [15:0] md, input logic ml,
                                       input logic bz, input logic dn, input logic er);
        return {25'd0, sr, lxv, lxi, mv, md, ml, bz, dn, er};
    endfunction

    function automatic logic [63:0] outs();
        return pk(s_ready, l_x_valid, l_x_in, m_valid, m_data, m_last, busy, done, error);
    endfunction

    function automatic void add(input logic st, input logic sv, input logic [15:0] sd,
                                input logic [3:0] ov, input logic [63:0] xo, input logic mr,
                                input logic [63:0] ex);
        tbl.push_back('{st, sv, sd, ov, xo, mr, ex});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_feed", 64'({s_ready, busy}), 64'(2'b11));
    endtask

    task automatic feed(input bit gap, input int extra);
        int xfer;
        int pulses;
        xfer = 0;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (l_x_valid) begin
                pulses++;
                chk("lx_data", 64'(l_x_in), 64'(pulses));
            end
            if (pulses == 8) break;
            s_valid = gap ? c[0] : 1'b1;
            s_data  = 16'(xfer + 1);
            if (s_valid && s_ready) xfer++;
        end
        chk("lx_count", 64'(pulses), 64'd8);
        chk("s_ready_off", 64'(s_ready), 64'd0);
        for (int c = 0; c < extra; c++) begin
            s_valid = 1'b1;
            tick();
            chk("no_extra_lx", 64'({l_x_valid, s_ready}), 64'd0);
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input logic [63:0] ev, input int stall_idx, input int stall_n);
        int beats;
        int stalls;
        beats = 0;
        stalls = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (m_valid) begin
                chk("m_data", 64'(m_data), 64'(ev[beats*16 +: 16]));
                chk("m_last", 64'(m_last), 64'(beats == 3));
                if (beats == stall_idx && stalls < stall_n) begin
                    m_ready = 1'b0;
                    stalls++;
                end else begin
                    m_ready = 1'b1;
                    beats++;
                end
            end else begin
                m_ready = 1'b0;
            end
            if (beats == 4) break;
        end
        tick();
        m_ready = 1'b0;
        chk("beats", 64'(beats), 64'd4);
        chk("done_idle", 64'({done, busy, m_valid}), 64'(3'b100));
        tick();
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] xo_nom;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        l_o_valid = '0; l_x_out = '0; m_ready = 1'b0;
        #2 rst = 1'b0;
        #10;
        chk("reset_state", outs(), 64'd0);
        tick();
        rst = 1'b1;

        // Nominal inference as a cycle table: inputs for the row, outputs seen before they apply.
        xo_nom = {16'd40, 16'd30, 16'd20, 16'd10};
        add(1'b1, 1'b0, 16'd0, 4'h0, 64'd0, 1'b0, pk(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(1'b0, 1'b1, 16'd1, 4'h0, 64'd0, 1'b0, pk(1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int k = 2; k <= 8; k++)
            add(1'b0, 1'b1, 16'(k), 4'h0, 64'd0, 1'b0,
                pk(1'b1, 1'b1, 16'(k - 1), 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b0, 1'b0, 16'd0, 4'hF, xo_nom, 1'b0, pk(1'b0, 1'b1, 16'd8, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b0, 1'b0, 16'd0, 4'h0, 64'd0, 1'b1, pk(1'b0, 1'b0, 16'd8, 1'b1, 16'd10, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b0, 1'b0, 16'd0, 4'h0, 64'd0, 1'b1, pk(1'b0, 1'b0, 16'd8, 1'b1, 16'd20, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b0, 1'b0, 16'd0, 4'h0, 64'd0, 1'b1, pk(1'b0, 1'b0, 16'd8, 1'b1, 16'd30, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b0, 1'b0, 16'd0, 4'h0, 64'd0, 1'b1, pk(1'b0, 1'b0, 16'd8, 1'b1, 16'd40, 1'b1, 1'b1, 1'b0, 1'b0));
        add(1'b0, 1'b0, 16'd0, 4'h0, 64'd0, 1'b0, pk(1'b0, 1'b0, 16'd8, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        add(1'b0, 1'b0, 16'd0, 4'h0, 64'd0, 1'b0, pk(1'b0, 1'b0, 16'd8, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            tick();
            chk($sformatf("vec%0d", i), outs(), tbl[i].ex);
            start     = tbl[i].st;
            s_valid   = tbl[i].sv;
            s_data    = tbl[i].sd;
            l_o_valid = tbl[i].ov;
            l_x_out   = tbl[i].xo;
            m_ready   = tbl[i].mr;
        end

        // Gapped input, staggered neuron completion with a repeated pulse, then output backpressure.
        do_start();
        feed(1'b1, 3);
        l_o_valid = 4'b0101;
        l_x_out   = {16'hDEAD, 16'd30, 16'hDEAD, 16'd5};
        tick();
        chk("stag_a", 64'(m_valid), 64'd0);
        l_o_valid = 4'b1001;
        l_x_out   = {16'd40, 16'hDEAD, 16'hDEAD, 16'd10};
        tick();
        chk("stag_b", 64'(m_valid), 64'd0);
        l_o_valid = 4'b0010;
        l_x_out   = {16'hDEAD, 16'hDEAD, 16'd20, 16'hDEAD};
        tick();
        chk("stag_drain", 64'(m_valid), 64'd1);
        l_o_valid = 4'b1111;
        l_x_out   = {16'hBAD3, 16'hBAD2, 16'hBAD1, 16'hBAD0};
        drain({16'd40, 16'd30, 16'd20, 16'd10}, 2, 5);
        l_o_valid = '0;

        // Reset after three accepted samples, then a full fresh inference.
        do_start();
        for (int k = 1; k <= 3; k++) begin
            tick();
            s_valid = 1'b1;
            s_data  = 16'(k);
        end
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("rst_mid_feed", outs(), 64'd0);
        tick();
        rst = 1'b1;
        do_start();
        feed(1'b0, 0);
        tick();
        chk("no_stale_out", 64'(m_valid), 64'd0);
        l_o_valid = 4'b1111;
        l_x_out   = {16'd4, 16'd3, 16'd2, 16'd1};
        tick();
        chk("rst_drain", 64'(m_valid), 64'd1);
        l_o_valid = '0;
        drain({16'd4, 16'd3, 16'd2, 16'd1}, 9, 0);

`ifdef LAYER_SEQ_TIMEOUT_EN
        // Incomplete mask must time out after 16 WAIT cycles; start recovers from ERR.
        do_start();
        feed(1'b0, 0);
        l_o_valid = 4'b0111;
        l_x_out   = {16'd0, 16'd7, 16'd6, 16'd5};
        n = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            l_o_valid = '0;
            if (error) break;
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'd16);
        chk("tmo_err", 64'({error, busy, s_ready}), 64'(3'b110));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_restart", 64'({error, busy, s_ready}), 64'(3'b011));
        feed(1'b0, 0);
        l_o_valid = 4'b1111;
        l_x_out   = {16'd14, 16'd13, 16'd12, 16'd11};
        tick();
        l_o_valid = '0;
        chk("err_recover", 64'(m_valid), 64'd1);
        drain({16'd14, 16'd13, 16'd12, 16'd11}, 9, 0);
`else
        n = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
